// File: rtl/myproject_mul_share_pkg.sv
// rtl/myproject_mul_share_pkg.sv - shared widths, transaction types and helpers for the shared multiplier
package myproject_mul_share_pkg;

  localparam int DEF_A_WIDTH  = 24;
  localparam int DEF_B_WIDTH  = 18;
  localparam int DEF_P_WIDTH  = 34;
  localparam int MAX_ID_WIDTH = 4;

  // Operand transaction at the default widths (ID sized for the largest requester count)
  typedef struct packed {
    logic [DEF_A_WIDTH-1:0]        a;
    logic signed [DEF_B_WIDTH-1:0] b;
    logic [MAX_ID_WIDTH-1:0]       id;
  } mul_req_t;

  // Product transaction at the default widths
  typedef struct packed {
    logic [DEF_P_WIDTH-1:0]  p;
    logic [MAX_ID_WIDTH-1:0] id;
  } mul_res_t;

  // Round-robin successor of a requester index, wrapping at n
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/myproject_mul_share_mul.sv
// rtl/myproject_mul_share_mul.sv - combinational unsigned x signed truncating multiplier
module myproject_mul_share_mul #(
  parameter int A_WIDTH = 24,
  parameter int B_WIDTH = 18,
  parameter int P_WIDTH = 34
) (
  input  logic [A_WIDTH-1:0] a,
  input  logic [B_WIDTH-1:0] b,
  output logic [P_WIDTH-1:0] p
);

  // The low P_WIDTH bits of a product depend only on the low P_WIDTH bits of the
  // operands, so extending both to P_WIDTH and multiplying modulo 2^P_WIDTH gives
  // the truncated signed product directly. Assumes P_WIDTH >= A_WIDTH, B_WIDTH.
  logic [P_WIDTH-1:0] a_ext;
  logic [P_WIDTH-1:0] b_ext;

  assign a_ext = {{(P_WIDTH-A_WIDTH){1'b0}}, a};
  assign b_ext = {{(P_WIDTH-B_WIDTH){b[B_WIDTH-1]}}, b};
  assign p     = a_ext * b_ext;

endmodule

// File: rtl/myproject_mul_share_arb.sv
// rtl/myproject_mul_share_arb.sv - round-robin arbiter sharing one multiplier across requesters
module myproject_mul_share_arb
  import myproject_mul_share_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int A_WIDTH  = DEF_A_WIDTH,
  parameter int B_WIDTH  = DEF_B_WIDTH,
  parameter int P_WIDTH  = DEF_P_WIDTH,
  parameter int ID_WIDTH = $clog2(N_REQ)
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*A_WIDTH-1:0] req_a,
  input  logic [N_REQ*B_WIDTH-1:0] req_b,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [P_WIDTH-1:0]       res_data,
  output logic [ID_WIDTH-1:0]      res_id,
  output logic                     busy
);

  logic                s1_valid_q, s1_valid_d;
  logic [A_WIDTH-1:0]  s1_a_q, s1_a_d;
  logic [B_WIDTH-1:0]  s1_b_q, s1_b_d;
  logic [ID_WIDTH-1:0] s1_id_q, s1_id_d;
  logic                s2_valid_q, s2_valid_d;
  logic [P_WIDTH-1:0]  s2_p_q, s2_p_d;
  logic [ID_WIDTH-1:0] s2_id_q, s2_id_d;
  logic [ID_WIDTH-1:0] ptr_q, ptr_d;

  logic                win_found;
  logic [ID_WIDTH-1:0] win_id;
  logic                s2_load;
  logic                grant;
  logic [P_WIDTH-1:0]  mul_p;

  // Priority search starting at the round-robin pointer, wrapping at N_REQ
  always_comb begin
    int idx;
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        win_id    = ID_WIDTH'(idx);
      end
    end
  end

  // S2 takes S1 whenever it is empty or being drained; S1 refills in the same cycle
  assign s2_load   = s1_valid_q && (!s2_valid_q || res_ready);
  assign grant     = win_found && (!s1_valid_q || s2_load);
  assign req_ready = grant ? (N_REQ'(1) << win_id) : '0;

  myproject_mul_share_mul #(
    .A_WIDTH (A_WIDTH),
    .B_WIDTH (B_WIDTH),
    .P_WIDTH (P_WIDTH)
  ) u_mul (
    .a (s1_a_q),
    .b (s1_b_q),
    .p (mul_p)
  );

  // Next-state for both pipeline stages and the arbitration pointer
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_id_d    = s1_id_q;
    s2_valid_d = s2_valid_q;
    s2_p_d     = s2_p_q;
    s2_id_d    = s2_id_q;
    ptr_d      = ptr_q;

    if (grant) begin
      s1_valid_d = 1'b1;
      s1_a_d     = req_a[int'(win_id)*A_WIDTH +: A_WIDTH];
      s1_b_d     = req_b[int'(win_id)*B_WIDTH +: B_WIDTH];
      s1_id_d    = win_id;
      ptr_d      = ID_WIDTH'(rr_next(int'(win_id), N_REQ));
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end

    if (s2_load) begin
      s2_valid_d = 1'b1;
      s2_p_d     = mul_p;
      s2_id_d    = s1_id_q;
    end else if (res_ready) begin
      s2_valid_d = 1'b0;
    end
  end

  // State registers; reset drops any in-flight work
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_id_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_p_q     <= '0;
      s2_id_q    <= '0;
      ptr_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_id_q    <= s1_id_d;
      s2_valid_q <= s2_valid_d;
      s2_p_q     <= s2_p_d;
      s2_id_q    <= s2_id_d;
      ptr_q      <= ptr_d;
    end
  end

  assign res_valid = s2_valid_q;
  assign res_data  = s2_p_q;
  assign res_id    = s2_id_q;
  assign busy      = s1_valid_q | s2_valid_q;

endmodule
